// File: rtl/sbp_pkg.sv
// sbp_pkg: shared widths, scheduler state and update-entry types for the SBP lookup head
package sbp_pkg;
  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int ADDR_BITS     = 11;
  localparam int DATA_BITS     = 64;

  typedef enum logic [1:0] {RUN, DRAIN, WRITE} sched_state_t;

  typedef struct packed {
    logic [STAGE_ID_BITS-1:0] stage;
    logic [ADDR_BITS-1:0]     addr;
    logic [DATA_BITS-1:0]     data;
  } upd_entry_t;

  // stage id 0 is the bubble id and ids past the chain address nothing
  function automatic logic stage_ok(input logic [STAGE_ID_BITS-1:0] s, input int n);
    return s != '0 && int'(s) <= n;
  endfunction
endpackage

// File: rtl/sbp_lookup_scheduler_if.sv
// sbp_lookup_scheduler_if: lookup, update, commit, pipeline and stage-write signals of the scheduler
interface sbp_lookup_scheduler_if;
  import sbp_pkg::*;
  logic                                 lk_valid;
  logic                                 lk_ready;
  logic [31:0]                          lk_ip_addr;
  logic                                 upd_valid;
  logic                                 upd_ready;
  logic [STAGE_ID_BITS-1:0]             upd_stage;
  logic [ADDR_BITS-1:0]                 upd_addr;
  logic [DATA_BITS-1:0]                 upd_data;
  logic                                 commit;
  logic                                 commit_done;
  logic                                 busy;
  logic                                 pipe_valid;
  logic [5:0]                           bit_pos;
  logic [STAGE_ID_BITS-1:0]             stage_id;
  logic [LOCATION_BITS-1:0]             location;
  logic [LOCATION_BITS+STAGE_ID_BITS-1:0] result;
  logic [31:0]                          ip_addr;
  logic                                 wr_en;
  logic [STAGE_ID_BITS-1:0]             wr_stage;
  logic [ADDR_BITS-1:0]                 wr_addr;
  logic [DATA_BITS-1:0]                 wr_data;

  modport master (
    output lk_valid, lk_ip_addr, upd_valid, upd_stage, upd_addr, upd_data, commit,
    input  lk_ready, upd_ready, commit_done, busy, pipe_valid, bit_pos, stage_id,
           location, result, ip_addr, wr_en, wr_stage, wr_addr, wr_data
  );

  modport slave (
    input  lk_valid, lk_ip_addr, upd_valid, upd_stage, upd_addr, upd_data, commit,
    output lk_ready, upd_ready, commit_done, busy, pipe_valid, bit_pos, stage_id,
           location, result, ip_addr, wr_en, wr_stage, wr_addr, wr_data
  );
endinterface

// File: rtl/sbp_sync_fifo.sv
// sbp_sync_fifo: show-ahead synchronous FIFO; caller never pushes when full nor pops when empty
module sbp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  assign dout = mem[rd_ptr];

  // storage needs no reset: clearing the pointers discards the contents
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/sbp_lookup_scheduler.sv
// sbp_lookup_scheduler: admits lookups and commits batched node writes only after the chain drains
module sbp_lookup_scheduler
  import sbp_pkg::*;
#(
  parameter int NUM_STAGES = 24,
  parameter int UPD_DEPTH  = 8
) (
  input logic                   clk,
  input logic                   rst,
  sbp_lookup_scheduler_if.slave bus
);
  localparam int DRAIN_CYCLES = 2*NUM_STAGES+1;
  localparam int CW = $clog2(DRAIN_CYCLES+1);
  localparam int QW = $clog2(UPD_DEPTH+1);

  sched_state_t  state, state_d;
  logic [CW-1:0] drain_cnt, drain_cnt_d;
  logic [QW-1:0] batch_rem, batch_rem_d, fifo_count, count_d;
  logic          accept, push, pop, last_pop, pend;
  upd_entry_t    entry, head;

  assign accept   = bus.lk_valid & bus.lk_ready;
  assign push     = bus.upd_valid & bus.upd_ready;
  assign pop      = state == WRITE;
  assign last_pop = pop & (batch_rem == QW'(1));
  assign count_d  = fifo_count + QW'(push) - QW'(pop);
  assign pend     = state == RUN & (bus.commit | count_d == QW'(UPD_DEPTH));
  assign entry    = '{stage: bus.upd_stage, addr: bus.upd_addr, data: bus.upd_data};

  assign bus.bit_pos  = '0;
  assign bus.location = '0;
  assign bus.result   = '0;
  assign bus.busy     = state != RUN;

  sbp_sync_fifo #(.WIDTH($bits(upd_entry_t)), .DEPTH(UPD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  // next state: the batch size is frozen when leaving RUN so later pushes wait for the next commit
  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    batch_rem_d = batch_rem;
    case (state)
      RUN: if (pend && count_d != '0) begin
        state_d     = DRAIN;
        drain_cnt_d = CW'(DRAIN_CYCLES);
        batch_rem_d = count_d;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt - CW'(1);
        state_d     = drain_cnt == CW'(1) ? WRITE : DRAIN;
      end
      WRITE: begin
        batch_rem_d = batch_rem - QW'(1);
        state_d     = last_pop ? RUN : WRITE;
      end
      default: state_d = RUN;
    endcase
  end

  // registered FSM state and every registered output
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state           <= RUN;
      drain_cnt       <= '0;
      batch_rem       <= '0;
      bus.lk_ready    <= 1'b0;
      bus.upd_ready   <= 1'b0;
      bus.commit_done <= 1'b0;
      bus.pipe_valid  <= 1'b0;
      bus.stage_id    <= '0;
      bus.ip_addr     <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_stage    <= '0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
    end else begin
      state           <= state_d;
      drain_cnt       <= drain_cnt_d;
      batch_rem       <= batch_rem_d;
      bus.lk_ready    <= state_d == RUN;
      bus.upd_ready   <= state_d != WRITE && count_d != QW'(UPD_DEPTH);
      bus.commit_done <= last_pop | (pend & count_d == '0);
      bus.pipe_valid  <= accept;
      bus.stage_id    <= accept ? STAGE_ID_BITS'(1) : '0;
      bus.ip_addr     <= accept ? bus.lk_ip_addr : '0;
      bus.wr_en       <= pop & stage_ok(head.stage, NUM_STAGES);
      bus.wr_stage    <= pop ? head.stage : bus.wr_stage;
      bus.wr_addr     <= pop ? head.addr : bus.wr_addr;
      bus.wr_data     <= pop ? head.data : bus.wr_data;
    end
endmodule
